// File: rtl/game_state_ctrl.sv
// Top-level platformer game-flow controller: start/pause/death/level-clear
// sequencing with a lives counter, level index and timed DYING/LEVEL_CLEAR phases.
module game_state_ctrl #(
  parameter int LIVES        = 3,
  parameter int LEVELS       = 4,
  parameter int DEATH_CYCLES = 64,
  parameter int CLEAR_CYCLES = 64,
  parameter int TW = $clog2(((DEATH_CYCLES > CLEAR_CYCLES) ? DEATH_CYCLES : CLEAR_CYCLES) + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          restart,
  input  logic          pause,
  input  logic          over,
  input  logic          success,
  output logic [2:0]    state,
  output logic [3:0]    lives,
  output logic [3:0]    level,
  output logic [TW-1:0] phase_timer,
  output logic          state_chg,
  output logic          respawn,
  output logic          level_up
);

  // Codes 0-3 are shared with the renderer's existing decode.
  typedef enum logic [2:0] {
    S_INITIAL     = 3'd0,
    S_RUNNING     = 3'd1,
    S_OVER        = 3'd2,
    S_SUCCESS     = 3'd3,
    S_PAUSED      = 3'd4,
    S_DYING       = 3'd5,
    S_LEVEL_CLEAR = 3'd6
  } state_e;

  localparam logic [TW-1:0] DEATH_LAST = TW'(DEATH_CYCLES - 1);
  localparam logic [TW-1:0] CLEAR_LAST = TW'(CLEAR_CYCLES - 1);
  localparam logic [3:0]    LIVES_INIT = 4'(LIVES);
  localparam logic [3:0]    LAST_LEVEL = 4'(LEVELS - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_INITIAL;
      lives       <= LIVES_INIT;
      level       <= 4'd0;
      phase_timer <= '0;
      state_chg   <= 1'b0;
      respawn     <= 1'b0;
      level_up    <= 1'b0;
    end else begin
      state_chg <= 1'b0;
      respawn   <= 1'b0;
      level_up  <= 1'b0;
      if (restart && state != S_INITIAL) begin
        state       <= S_INITIAL;
        lives       <= LIVES_INIT;
        level       <= 4'd0;
        phase_timer <= '0;
        state_chg   <= 1'b1;
      end else begin
        case (state)
          S_INITIAL: begin
            if (start && !restart) begin
              state     <= S_RUNNING;
              state_chg <= 1'b1;
            end
          end
          S_RUNNING: begin
            if (over) begin
              state       <= S_DYING;
              lives       <= (lives != 4'd0) ? lives - 4'd1 : 4'd0;
              phase_timer <= '0;
              state_chg   <= 1'b1;
            end else if (success) begin
              state       <= S_LEVEL_CLEAR;
              phase_timer <= '0;
              state_chg   <= 1'b1;
            end else if (pause) begin
              state     <= S_PAUSED;
              state_chg <= 1'b1;
            end
          end
          S_PAUSED: begin
            if (pause) begin
              state     <= S_RUNNING;
              state_chg <= 1'b1;
            end
          end
          S_DYING: begin
            if (phase_timer == DEATH_LAST) begin
              phase_timer <= '0;
              state_chg   <= 1'b1;
              if (lives == 4'd0) begin
                state <= S_OVER;
              end else begin
                state   <= S_RUNNING;
                respawn <= 1'b1;
              end
            end else begin
              phase_timer <= phase_timer + TW'(1);
            end
          end
          S_LEVEL_CLEAR: begin
            if (phase_timer == CLEAR_LAST) begin
              phase_timer <= '0;
              state_chg   <= 1'b1;
              if (level == LAST_LEVEL) begin
                state <= S_SUCCESS;
              end else begin
                state    <= S_RUNNING;
                level    <= level + 4'd1;
                level_up <= 1'b1;
              end
            end else begin
              phase_timer <= phase_timer + TW'(1);
            end
          end
          S_OVER, S_SUCCESS: begin
          end
          default: begin
            // Unused code 7: fall back to a clean INITIAL.
            state       <= S_INITIAL;
            lives       <= LIVES_INIT;
            level       <= 4'd0;
            phase_timer <= '0;
            state_chg   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
